// File: rtl/dmem_arbiter.sv
// Two-requester (core/loader) data-memory arbiter with round-robin tie-break.
// One fixed-latency memory transaction at a time: IDLE -> ISSUE -> [WAIT] -> DONE.
module dmem_arbiter #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [BUS_WIDTH-1:0]  c_wdata,
    output logic                  c_gnt,
    output logic                  c_done,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [BUS_WIDTH-1:0]  l_wdata,
    output logic                  l_gnt,
    output logic                  l_done,
    output logic [BUS_WIDTH-1:0]  rdata,
    output logic                  busy,
    output logic                  m_en,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [BUS_WIDTH-1:0]  m_wdata,
    input  logic [BUS_WIDTH-1:0]  m_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic       LatOne  = (MEM_LAT == 1);
    localparam logic [2:0] CntInit = (MEM_LAT >= 2) ? 3'(MEM_LAT - 2) : 3'd0;

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    // last_q doubles as the current winner once a transaction is under way (1 = loader).
    logic                  last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  win_loader;

    // With both requesting, the requester that did not win last time goes next.
    assign win_loader = l_req & (~c_req | ~last_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (c_req || l_req) begin
                    state_d = ISSUE;
                    last_d  = win_loader;
                    we_d    = win_loader ? l_we    : c_we;
                    addr_d  = win_loader ? l_addr  : c_addr;
                    wdata_d = win_loader ? l_wdata : c_wdata;
                end
            end
            ISSUE: begin
                if (LatOne) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = m_rdata;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CntInit;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = m_rdata;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from state and registers only; no request-to-output path.
    assign busy    = (state_q != IDLE);
    assign m_en    = (state_q == ISSUE);
    assign m_we    = m_en & we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign c_gnt   = m_en & ~last_q;
    assign l_gnt   = m_en & last_q;
    assign c_done  = (state_q == DONE) & ~last_q;
    assign l_done  = (state_q == DONE) & last_q;
    assign rdata   = rdata_q;

endmodule
